wb_dma_copy: RTL and testbench
==============================

// Module: wb_dma_copy
// PURPOSE
//  Pipelined-Wishbone bus initiator that copies a block of 32-bit words from a source to a destination address.
//  Issues pipelined read bursts into an internal FIFO, then pipelined write bursts out of it.
//  Sits beside the cpu as a second Controller on a data bus; exercises wbram-style Peripherals from the controller side.
// PARAMETERS
//  FIFO_DEPTH      8    words per burst / FIFO entries; power of 2, >=2
//  LEN_WIDTH       16   width of transfer length in words
//  TIMEOUT_CYCLES  256  ack watchdog limit (WB_TIMEOUT_EN only)
// PORTS
//  i_clk         in   1          clock
//  i_rst_n       in   1          asynchronous reset, active-low
//  i_start       in   1          start request, sampled only in IDLE
//  i_src_addr    in   32         source byte address; bits [1:0] ignored
//  i_dst_addr    in   32         destination byte address; bits [1:0] ignored
//  i_len_words   in   LEN_WIDTH  number of words to copy
//  o_busy        out  1          high from the cycle after accepted start until completion
//  o_done        out  1          one-cycle completion pulse (success or error)
//  o_err         out  1          sticky error flag; cleared on next accepted start
//  o_wb_cyc      out  1          Wishbone cycle
//  o_wb_stb      out  1          Wishbone strobe
//  o_wb_we       out  1          write enable
//  o_wb_addr     out  32         word-aligned byte address
//  o_wb_data     out  32         write data
//  o_wb_sel      out  4          byte select, always 4'hF
//  i_wb_stall    in   1          pipelined stall
//  i_wb_ack      in   1          acknowledge
//  i_wb_err      in   1          bus error
//  i_wb_data     in   32         read data
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, FIFO empty, counters 0.
//  - States: IDLE -> RD -> TURN -> WR -> TURN -> RD ... -> DONE -> IDLE. ERR path: any -> DONE.
//  - IDLE: i_start=1 latches src, dst, len and clears o_err.
//    - len==0: go to DONE directly, no bus activity.
//    - Otherwise: chunk=min(remaining,FIFO_DEPTH); go to RD.
//  - RD: cyc=1, we=0.
//    - stb held while issued<chunk; a request is accepted when stb & !stall.
//    - On acceptance: addr+=4, issued++.
//    - Each ack pushes i_wb_data into the FIFO.
//    - When acks==chunk, go to TURN.
//  - TURN: exactly one cycle, cyc=stb=0.
//    - Next state is WR if leaving RD.
//    - If leaving WR: RD when remaining>0, else DONE.
//  - WR: cyc=1, we=1; o_wb_data = FIFO head.
//    - Pop on acceptance; stb held while FIFO non-empty.
//    - Each ack decrements remaining.
//    - acks==chunk -> TURN.
//  - Source and destination address counters persist across chunks; addresses wrap modulo 2^32.
//  - DONE: one cycle, o_done=1, o_busy=0 from this cycle onward; then IDLE.
//  - i_wb_err while cyc=1 aborts the transfer:
//    - cyc and stb low the next cycle, FIFO flushed, o_err=1, go to DONE.
//    - err and ack in the same cycle: err wins, the ack is ignored.
//  - Ack/err with cyc=0 ignored. i_start while busy ignored.
//  - Max outstanding requests = chunk; FIFO can never overflow (chunk<=FIFO_DEPTH).
//  - Zero-wait peripheral (ack the cycle after accept, no stall): an N<=FIFO_DEPTH word copy completes in 2N+5 cycles from start to done pulse.
// CONFIGURATION
//  WB_TIMEOUT_EN defined:
//    - A watchdog counts cycles in RD/WR with outstanding requests and no ack/err; it resets on any ack.
//    - Reaching TIMEOUT_CYCLES aborts exactly like i_wb_err (o_err=1).
//  WB_TIMEOUT_EN undefined: no watchdog; a silent peripheral hangs the engine in RD/WR until reset.
// TESTING
//  1 reset: drive i_rst_n=0 mid-RD burst -> all outputs 0 at once; after release, a fresh start copies correctly.
//  2 src=0x4000_0000, dst=0x4000_0100, len=5, zero-wait RAM -> 5 reads, TURN, 5 writes; dst words equal src; o_done at cycle 15.
//  3 len=20, FIFO_DEPTH=8, RAM LATENCY 7 with random stall -> chunks 8,8,4; data intact; outstanding never exceeds 8.
//  4 len=0 -> o_done one cycle later, o_wb_cyc never asserted, o_err=0.
//  5 i_wb_err on 3rd read ack -> cyc low next cycle, o_done=1 with o_err=1, no writes issued; next start clears o_err.
//  6 WB_TIMEOUT_EN, TIMEOUT_CYCLES=16, peripheral never acks -> abort 16 cycles after first accept, o_err=1.

Source files
------------

// File: rtl/wb_dma_copy.sv
// wb_dma_copy: pipelined Wishbone initiator that copies a block of 32-bit words
// from a source to a destination address. Each chunk of up to FIFO_DEPTH
// words is read into an internal FIFO and then written back out. A one-cycle
// bus-idle TURN state separates every read and write burst.
//
// Optional feature: define WB_TIMEOUT_EN to enable the ack watchdog.
//
// Ports
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_start               start request (sampled only in IDLE)
//   i_src_addr/dst_addr   byte addresses, low two bits ignored
//   i_len_words           number of words to copy
//   o_busy/o_done/o_err   status: busy, one-cycle done pulse, sticky error
//   o_wb_*                Wishbone initiator outputs (cyc, stb, we, addr, data, sel)
//   i_wb_*                Wishbone responses (stall, ack, err, data)
module wb_dma_copy #(
    parameter int unsigned FIFO_DEPTH     = 8,
    parameter int unsigned LEN_WIDTH      = 16,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_start,
    input  logic [31:0]          i_src_addr,
    input  logic [31:0]          i_dst_addr,
    input  logic [LEN_WIDTH-1:0] i_len_words,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_err,
    output logic                 o_wb_cyc,
    output logic                 o_wb_stb,
    output logic                 o_wb_we,
    output logic [31:0]          o_wb_addr,
    output logic [31:0]          o_wb_data,
    output logic [3:0]           o_wb_sel,
    input  logic                 i_wb_stall,
    input  logic                 i_wb_ack,
    input  logic                 i_wb_err,
    input  logic [31:0]          i_wb_data
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    // Reject configurations the FIFO pointer arithmetic cannot support.
    generate
        if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT_CYCLES == 0) begin : g_param_check
            $error("wb_dma_copy: FIFO_DEPTH must be a power of 2 >= 2 and TIMEOUT_CYCLES > 0");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_TURN,
        S_WR,
        S_DONE
    } state_t;

    state_t               state_q, state_n;
    logic [31:0]          src_q, src_n;
    logic [31:0]          dst_q, dst_n;
    logic [LEN_WIDTH-1:0] rem_q, rem_n;
    logic [CNT_W-1:0]     chunk_q, chunk_n;
    logic [CNT_W-1:0]     issued_q, issued_n;
    logic [CNT_W-1:0]     acks_q, acks_n;
    logic                 to_wr_q, to_wr_n;

    logic [31:0]          fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wptr_q, wptr_n;
    logic [PTR_W-1:0]     rptr_q, rptr_n;
    logic [CNT_W-1:0]     cnt_q, cnt_n;
    logic                 push, pop, flush;

    logic                 busy_n, done_n, err_n;
    logic                 cyc_n, stb_n, we_n;
    logic [31:0]          addr_n, wdata_n;

    logic                 accept, bus_ack, bus_err, abort;

    // Bus handshake qualifiers; responses outside a cycle are ignored, err beats ack.
    assign accept  = o_wb_stb & ~i_wb_stall;
    assign bus_ack = o_wb_cyc & i_wb_ack & ~i_wb_err;
    assign bus_err = o_wb_cyc & i_wb_err;

`ifdef WB_TIMEOUT_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] wd_q;
    logic            wd_count, wd_hit;

    // Count cycles with requests in flight (including the accepting cycle) and no response.
    assign wd_count = o_wb_cyc & ((issued_q != acks_q) | accept) & ~i_wb_ack & ~i_wb_err;
    assign wd_hit   = wd_count & (wd_q == WD_W'(TIMEOUT_CYCLES - 1));
    assign abort    = bus_err | wd_hit;

    // Watchdog counter, cleared whenever the bus is responsive or idle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wd_q <= '0;
        end else if (!wd_count) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_q + WD_W'(1);
        end
    end
`else
    assign abort = bus_err;
`endif

    // Words for the next chunk: min(remaining, FIFO_DEPTH).
    function automatic logic [CNT_W-1:0] chunk_of(input logic [LEN_WIDTH-1:0] r);
        if (r < LEN_WIDTH'(FIFO_DEPTH)) begin
            return CNT_W'(r);
        end
        return CNT_W'(FIFO_DEPTH);
    endfunction

    // Next-state, counters, FIFO control and next-cycle output values.
    always_comb begin
        state_n  = state_q;
        src_n    = src_q;
        dst_n    = dst_q;
        rem_n    = rem_q;
        chunk_n  = chunk_q;
        issued_n = issued_q;
        acks_n   = acks_q;
        to_wr_n  = to_wr_q;
        err_n    = o_err;
        push     = 1'b0;
        pop      = 1'b0;
        flush    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    src_n    = i_src_addr & 32'hFFFF_FFFC;
                    dst_n    = i_dst_addr & 32'hFFFF_FFFC;
                    rem_n    = i_len_words;
                    err_n    = 1'b0;
                    issued_n = '0;
                    acks_n   = '0;
                    chunk_n  = chunk_of(i_len_words);
                    state_n  = (i_len_words == '0) ? S_DONE : S_RD;
                end
            end
            S_RD: begin
                if (accept) begin
                    src_n    = src_q + 32'd4;
                    issued_n = issued_q + CNT_W'(1);
                end
                if (bus_ack) begin
                    push   = 1'b1;
                    acks_n = acks_q + CNT_W'(1);
                end
                if (abort) begin
                    flush   = 1'b1;
                    err_n   = 1'b1;
                    state_n = S_DONE;
                end else if (acks_n == chunk_q) begin
                    to_wr_n = 1'b1;
                    state_n = S_TURN;
                end
            end
            S_TURN: begin
                issued_n = '0;
                acks_n   = '0;
                if (to_wr_q) begin
                    state_n = S_WR;
                end else if (rem_q != '0) begin
                    chunk_n = chunk_of(rem_q);
                    state_n = S_RD;
                end else begin
                    state_n = S_DONE;
                end
            end
            S_WR: begin
                if (accept) begin
                    pop      = 1'b1;
                    dst_n    = dst_q + 32'd4;
                    issued_n = issued_q + CNT_W'(1);
                end
                if (bus_ack) begin
                    rem_n  = rem_q - LEN_WIDTH'(1);
                    acks_n = acks_q + CNT_W'(1);
                end
                if (abort) begin
                    flush   = 1'b1;
                    err_n   = 1'b1;
                    state_n = S_DONE;
                end else if (acks_n == chunk_q) begin
                    to_wr_n = 1'b0;
                    state_n = S_TURN;
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

        wptr_n = wptr_q + PTR_W'(push);
        rptr_n = rptr_q + PTR_W'(pop);
        cnt_n  = cnt_q + CNT_W'(push) - CNT_W'(pop);
        if (flush) begin
            wptr_n = '0;
            rptr_n = '0;
            cnt_n  = '0;
        end

        // Outputs are registered, so they are derived from the next state.
        busy_n  = (state_n == S_RD) || (state_n == S_TURN) || (state_n == S_WR);
        done_n  = (state_n == S_DONE);
        cyc_n   = (state_n == S_RD) || (state_n == S_WR);
        we_n    = (state_n == S_WR);
        stb_n   = ((state_n == S_RD) && (issued_n < chunk_n)) ||
                  ((state_n == S_WR) && (cnt_n != '0));
        addr_n  = (state_n == S_RD) ? src_n : ((state_n == S_WR) ? dst_n : 32'd0);
        // FIFO is never written while in WR, so the head read here is stable.
        wdata_n = (state_n == S_WR) ? fifo_mem[rptr_n] : 32'd0;
    end

    // State, counters and registered outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= S_IDLE;
            src_q     <= '0;
            dst_q     <= '0;
            rem_q     <= '0;
            chunk_q   <= '0;
            issued_q  <= '0;
            acks_q    <= '0;
            to_wr_q   <= 1'b0;
            wptr_q    <= '0;
            rptr_q    <= '0;
            cnt_q     <= '0;
            o_busy    <= 1'b0;
            o_done    <= 1'b0;
            o_err     <= 1'b0;
            o_wb_cyc  <= 1'b0;
            o_wb_stb  <= 1'b0;
            o_wb_we   <= 1'b0;
            o_wb_addr <= '0;
            o_wb_data <= '0;
            o_wb_sel  <= 4'h0;
        end else begin
            state_q   <= state_n;
            src_q     <= src_n;
            dst_q     <= dst_n;
            rem_q     <= rem_n;
            chunk_q   <= chunk_n;
            issued_q  <= issued_n;
            acks_q    <= acks_n;
            to_wr_q   <= to_wr_n;
            wptr_q    <= wptr_n;
            rptr_q    <= rptr_n;
            cnt_q     <= cnt_n;
            o_busy    <= busy_n;
            o_done    <= done_n;
            o_err     <= err_n;
            o_wb_cyc  <= cyc_n;
            o_wb_stb  <= stb_n;
            o_wb_we   <= we_n;
            o_wb_addr <= addr_n;
            o_wb_data <= wdata_n;
            o_wb_sel  <= 4'hF;
        end
    end

    // FIFO storage; contents are don't-care until written.
    always_ff @(posedge i_clk) begin
        if (push && !flush) begin
            fifo_mem[wptr_q] <= i_wb_data;
        end
    end

endmodule

// File: tb/tb_wb_dma_copy.sv
// Testbench for wb_dma_copy: directed copies against a bench-side RAM
// peripheral, with a transfer-level model checked on every bus cycle.
module tb_wb_dma_copy;

    localparam int DEPTH = 8;
    localparam int LW    = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_start = 1'b0;
    logic [31:0]   i_src_addr = '0;
    logic [31:0]   i_dst_addr = '0;
    logic [LW-1:0] i_len_words = '0;
    logic          o_busy, o_done, o_err;
    logic          o_wb_cyc, o_wb_stb, o_wb_we;
    logic [31:0]   o_wb_addr, o_wb_data;
    logic [3:0]    o_wb_sel;
    logic          i_wb_stall = 1'b0;
    logic          i_wb_ack = 1'b0;
    logic          i_wb_err = 1'b0;
    logic [31:0]   i_wb_data = '0;

    wb_dma_copy #(
        .FIFO_DEPTH    (DEPTH),
        .LEN_WIDTH     (LW),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_start    (i_start),
        .i_src_addr (i_src_addr),
        .i_dst_addr (i_dst_addr),
        .i_len_words(i_len_words),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_err      (o_err),
        .o_wb_cyc   (o_wb_cyc),
        .o_wb_stb   (o_wb_stb),
        .o_wb_we    (o_wb_we),
        .o_wb_addr  (o_wb_addr),
        .o_wb_data  (o_wb_data),
        .o_wb_sel   (o_wb_sel),
        .i_wb_stall (i_wb_stall),
        .i_wb_ack   (i_wb_ack),
        .i_wb_err   (i_wb_err),
        .i_wb_data  (i_wb_data)
    );

    initial forever #5 clk = ~clk;

    int cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic check_outputs_zero(input string name);
        check({name, "_ctrl"}, 64'({o_busy, o_done, o_err, o_wb_cyc, o_wb_stb, o_wb_we, o_wb_sel}), 64'd0);
        check({name, "_addr"}, 64'(o_wb_addr), 64'd0);
        check({name, "_data"}, 64'(o_wb_data), 64'd0);
    endtask

    // RAM peripheral: fixed ack latency, optional random stall, error injection, silent mode.
    logic [31:0] mem  [0:1023];
    logic [31:0] gold [0:1023];
    int          p_lat = 1;
    bit          p_stall_en = 1'b0;
    int          p_err_at = 0;
    int          p_rd_acks = 0;
    bit          p_silent = 1'b0;
    int          q_due [$];
    logic [31:0] q_dat [$];
    bit          q_we  [$];

    initial begin : periph
        logic        nack, nerr, nstall, rwe;
        logic [31:0] ndata;
        forever begin
            @(negedge clk);
            nack = 1'b0; nerr = 1'b0; nstall = 1'b0; ndata = '0;
            if (!rst_n || !o_wb_cyc) begin
                q_due.delete(); q_dat.delete(); q_we.delete();
            end else begin
                if (o_wb_stb && !i_wb_stall) begin
                    if (o_wb_we) begin
                        mem[o_wb_addr[11:2]] = o_wb_data;
                        q_dat.push_back(32'd0);
                    end else begin
                        q_dat.push_back(mem[o_wb_addr[11:2]]);
                    end
                    q_we.push_back(o_wb_we);
                    q_due.push_back(cyc_cnt + p_lat);
                end
                if (!p_silent && q_due.size() > 0 && q_due[0] <= cyc_cnt + 1) begin
                    nack  = 1'b1;
                    ndata = q_dat.pop_front();
                    rwe   = q_we.pop_front();
                    void'(q_due.pop_front());
                    if (!rwe && p_err_at != 0) begin
                        p_rd_acks++;
                        if (p_rd_acks == p_err_at) nerr = 1'b1;
                    end
                end
            end
            if (p_stall_en) nstall = ($urandom_range(0, 1) == 1);
            @(posedge clk);
            #1;
            i_wb_ack   = nack;
            i_wb_err   = nerr;
            i_wb_data  = ndata;
            i_wb_stall = nstall;
        end
    end

    // Transfer model: expected address/data sequence and chunk ordering.
    bit          m_on = 1'b0;
    logic [31:0] m_src, m_dst;
    int          m_len, m_rd, m_wr, m_out;
    bit          m_cyc_seen;

    initial begin : compare
        int need;
        forever begin
            @(negedge clk);
            if (rst_n && m_on) begin
                if (o_wb_cyc) begin
                    m_cyc_seen = 1'b1;
                    if (o_wb_stb && !i_wb_stall) begin
                        if (o_wb_we) begin
                            need = (m_wr / DEPTH + 1) * DEPTH;
                            if (need > m_len) need = m_len;
                            check("wr_addr", 64'(o_wb_addr), 64'(m_dst + 32'(4 * m_wr)));
                            check("wr_data", 64'(o_wb_data), 64'(gold[int'(m_src[11:2]) + m_wr]));
                            check("wr_chunk_reads_done", 64'(m_rd), 64'(need));
                            m_wr++;
                        end else begin
                            check("rd_addr", 64'(o_wb_addr), 64'(m_src + 32'(4 * m_rd)));
                            m_rd++;
                        end
                        m_out++;
                        check("outstanding_le_depth", 64'(m_out <= DEPTH), 64'd1);
                    end
                    check("sel", 64'(o_wb_sel), 64'hF);
                    if (i_wb_ack && !i_wb_err) m_out--;
                end else begin
                    m_out = 0;
                end
                check("done_not_busy", 64'(o_done && o_busy), 64'd0);
            end
        end
    end

    task automatic do_copy(input logic [31:0] src, input logic [31:0] dst, input int len,
                           output int c0, output int dcyc);
        @(negedge clk);
        m_src = src; m_dst = dst; m_len = len;
        m_rd = 0; m_wr = 0; m_out = 0; m_cyc_seen = 1'b0; m_on = 1'b1;
        i_src_addr = src; i_dst_addr = dst; i_len_words = LW'(len);
        i_start = 1'b1;
        c0 = cyc_cnt;
        @(negedge clk);
        i_start = 1'b0;
        if (len > 0) check("busy_after_start", 64'(o_busy), 64'd1);
        dcyc = -1;
        for (int i = 0; i < 3000 && dcyc < 0; i++) begin
            if (o_done) dcyc = cyc_cnt;
            else @(negedge clk);
        end
        check("done_seen", 64'(dcyc >= 0), 64'd1);
        if (dcyc >= 0) check("busy_low_at_done", 64'(o_busy), 64'd0);
        m_on = 1'b0;
    endtask

    initial begin : main
        int c0, d, seen;
        for (int i = 0; i < 1024; i++) begin
            mem[i]  = 32'hC0DE_0000 + 32'(i);
            gold[i] = mem[i];
        end

        // Reset state
        #2;
        check_outputs_zero("reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // 1: reset in the middle of a read burst
        p_lat = 3;
        @(negedge clk);
        i_src_addr = 32'h4000_0000; i_dst_addr = 32'h4000_0100; i_len_words = LW'(5);
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        seen = 0;
        for (int i = 0; i < 20 && seen == 0; i++) begin
            if (o_wb_cyc) seen = 1;
            else @(negedge clk);
        end
        check("t1_rd_started", 64'(seen), 64'd1);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_outputs_zero("t1_async_reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // 2: 5-word copy, zero-wait RAM
        p_lat = 1;
        do_copy(32'h4000_0000, 32'h4000_0100, 5, c0, d);
        check("t2_done_cycle", 64'(d - c0), 64'd15);
        check("t2_reads", 64'(m_rd), 64'd5);
        check("t2_writes", 64'(m_wr), 64'd5);
        check("t2_err", 64'(o_err), 64'd0);
        check("t2_dst0", 64'(mem[64]), 64'hC0DE_0000);
        check("t2_dst4", 64'(mem[68]), 64'hC0DE_0004);
        for (int i = 0; i < 5; i++) check("t2_dst_word", 64'(mem[64 + i]), 64'(gold[i]));

        // 3: 20-word copy, latency 7, random stall -> chunks 8,8,4
        p_lat = 7; p_stall_en = 1'b1;
        do_copy(32'h4000_0200, 32'h4000_0400, 20, c0, d);
        check("t3_reads", 64'(m_rd), 64'd20);
        check("t3_writes", 64'(m_wr), 64'd20);
        check("t3_err", 64'(o_err), 64'd0);
        check("t3_dst_last", 64'(mem[275]), 64'hC0DE_0093);
        for (int i = 0; i < 20; i++) check("t3_dst_word", 64'(mem[256 + i]), 64'(gold[128 + i]));
        p_lat = 1; p_stall_en = 1'b0;

        // 4: zero-length copy
        do_copy(32'h4000_0000, 32'h4000_0900, 0, c0, d);
        check("t4_done_cycle", 64'(d - c0), 64'd1);
        check("t4_no_cyc", 64'(m_cyc_seen), 64'd0);
        check("t4_err", 64'(o_err), 64'd0);

        // 5: bus error on 3rd read ack, then recovery clears the error
        p_err_at = 3; p_rd_acks = 0;
        do_copy(32'h4000_0000, 32'h4000_0A00, 5, c0, d);
        check("t5_done_cycle", 64'(d - c0), 64'd5);
        check("t5_err", 64'(o_err), 64'd1);
        check("t5_cyc_low", 64'(o_wb_cyc), 64'd0);
        check("t5_no_writes", 64'(m_wr), 64'd0);
        p_err_at = 0;
        @(negedge clk);
        check("t5_err_sticky", 64'(o_err), 64'd1);
        do_copy(32'h4000_0000, 32'h4000_0A00, 2, c0, d);
        check("t5b_done_cycle", 64'(d - c0), 64'd9);
        check("t5b_err_cleared", 64'(o_err), 64'd0);
        check("t5b_dst0", 64'(mem[640]), 64'hC0DE_0000);
        check("t5b_dst1", 64'(mem[641]), 64'hC0DE_0001);

`ifdef WB_TIMEOUT_EN
        // 6: silent peripheral trips the watchdog 16 cycles after the first accept
        p_silent = 1'b1;
        do_copy(32'h4000_0000, 32'h4000_0B00, 3, c0, d);
        check("t6_done_cycle", 64'(d - c0), 64'd17);
        check("t6_err", 64'(o_err), 64'd1);
        check("t6_no_writes", 64'(m_wr), 64'd0);
        p_silent = 1'b0;
`endif

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
